chess_board_arbiter: RTL and testbench

CHESS_BOARD_ARBITER -- requirements
Module: chess_board_arbiter

---
 rtl/chess_board_arbiter.sv | 144 ++++++++++++++
 tb/tb_chess_board_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_board_arbiter.sv
// Board RAM port arbiter: VGA reads own the port during active video, queued CPU writes drain in blanking.
// Optional macro ARB_COALESCE_EN merges a CPU write into a queued entry with the same square address.
module chess_board_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iBLANK_n,
    input  logic [ADDR_W-1:0] vga_address,
    output logic [31:0]       vga_data,
    input  logic              cpu_wr_req,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [31:0]       cpu_wr_data,
    output logic              cpu_wr_ack,
    output logic              cpu_full,
    output logic              err_sticky,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    output logic              mem_wren,
    input  logic [31:0]       mem_rdata
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_READ, S_GUARD, S_WRITE} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d, ack_q, ack_d, err_q, err_d, wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, hold_q, hold_d;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [31:0]       fifo_data [FIFO_DEPTH];

    logic          pop, oob, accept, push_new, coal_wr, hit;
    logic [PW-1:0] hit_idx, wr_idx;

    assign pop = (state_q == S_WRITE) && !iBLANK_n && (count_q != '0);
    assign oob = cpu_wr_addr > ADDR_W'(63);

`ifdef ARB_COALESCE_EN
    // Only live entries may match; the head leaving this cycle is excluded so the write gets a fresh slot.
    always_comb begin
        logic [PW-1:0] off;
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) && !(pop && off == '0) && fifo_addr[i] == cpu_wr_addr) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_idx = '0;
`endif

    assign accept   = cpu_wr_req && (!full_q || hit);
    assign push_new = accept && !oob && !hit;
    assign coal_wr  = accept && hit;
    assign wr_idx   = hit ? hit_idx : wr_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_new);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push_new) - CW'(pop);
        full_d   = (count_d == CW'(FIFO_DEPTH));
        ack_d    = accept;
        err_d    = err_q | (accept & oob);
        hold_d   = (state_q == S_READ) ? mem_rdata : hold_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wren_d  = 1'b0;
        case (state_q)
            S_READ: begin
                addr_d = vga_address;
                if (!iBLANK_n && count_q != '0) state_d = S_GUARD;
            end
            S_GUARD: state_d = iBLANK_n ? S_READ : S_WRITE;
            S_WRITE: begin
                if (pop) begin
                    addr_d  = fifo_addr[rd_ptr_q];
                    wdata_d = fifo_data[rd_ptr_q];
                    wren_d  = 1'b1;
                    if (count_d == '0) state_d = S_READ;
                end else begin
                    state_d = S_READ;
                end
            end
            default: state_d = S_READ;
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= S_READ;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
        end
    end

    // Queue storage needs no reset: only slots covered by count are ever read.
    always_ff @(posedge iVGA_CLK) begin
        if (push_new) fifo_addr[wr_idx] <= cpu_wr_addr;
        if (push_new || coal_wr) fifo_data[wr_idx] <= cpu_wr_data;
    end

    assign vga_data    = (state_q == S_READ) ? mem_rdata : hold_q;
    assign cpu_wr_ack  = ack_q;
    assign cpu_full    = full_q;
    assign err_sticky  = err_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wren    = wren_q;
endmodule

// File: tb/tb_chess_board_arbiter.sv
// Bench for chess_board_arbiter: queue-based reference model checked every cycle, plus directed literal cases.
module tb_chess_board_arbiter;
    localparam int DEPTH = 4;
    localparam int AW    = 12;

    logic          clk = 1'b0, rst_n = 1'b0, blank_n = 1'b1;
    logic [AW-1:0] vga_address = '0;
    logic [31:0]   vga_data;
    logic          req = 1'b0;
    logic [AW-1:0] wa = '0;
    logic [31:0]   wd = '0;
    logic          ack, full, err, mwren;
    logic [AW-1:0] maddr;
    logic [31:0]   mwdata;
    logic [31:0]   rdata = '0;

    chess_board_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iBLANK_n(blank_n),
        .vga_address(vga_address), .vga_data(vga_data),
        .cpu_wr_req(req), .cpu_wr_addr(wa), .cpu_wr_data(wd),
        .cpu_wr_ack(ack), .cpu_full(full), .err_sticky(err),
        .mem_address(maddr), .mem_wdata(mwdata), .mem_wren(mwren),
        .mem_rdata(rdata)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as a queue, port phase as 0=read, 1=turnaround, 2=drain.
    typedef struct packed {logic [AW-1:0] a; logic [31:0] d;} ent_t;
    ent_t          q[$];
    int            mode = 0;
    bit            m_full = 0, m_ack = 0, m_err = 0, m_wren = 0;
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_wdata = '0, m_hold = '0;

    task automatic model_step();
        ent_t head;
        bit   popped = 0, was_full = m_full, acc;
        int   hit = -1;
        if (mode == 0) m_hold = rdata;
        m_wren = 0;
        case (mode)
            0: begin
                m_addr = vga_address;
                if (!blank_n && q.size() > 0) mode = 1;
            end
            1: mode = blank_n ? 0 : 2;
            default: begin
                if (!blank_n && q.size() > 0) begin
                    head = q.pop_front();
                    popped = 1;
                    m_addr = head.a; m_wdata = head.d; m_wren = 1;
                end else mode = 0;
            end
        endcase
`ifdef ARB_COALESCE_EN
        foreach (q[i]) if (q[i].a == wa) hit = i;
`endif
        acc = req && (!was_full || hit >= 0);
        if (acc) begin
            if (wa > 63) m_err = 1;
            else if (hit >= 0) q[hit].d = wd;
            else q.push_back('{a: wa, d: wd});
        end
        if (popped && q.size() == 0) mode = 0;
        m_ack  = acc;
        m_full = (q.size() == DEPTH);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            mode = 0; m_full = 0; m_ack = 0; m_err = 0; m_wren = 0;
            m_addr = '0; m_wdata = '0; m_hold = '0;
        end else model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("m_wren", mwren, m_wren);
        chk("m_addr", maddr, m_addr);
        chk("m_wdata", mwdata, m_wdata);
        chk("m_ack", ack, m_ack);
        chk("m_full", full, m_full);
        chk("m_err", err, m_err);
        chk("m_vga_data", vga_data, (mode == 0) ? rdata : m_hold);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rdata = $urandom;
        vga_address = AW'($urandom_range(0, 63));
    endtask

    task automatic push(input int a, input int d);
        req = 1; wa = AW'(a); wd = d;
        tick();
        req = 0;
        chk("push_ack", ack, 1);
    endtask

    task automatic wait_wren(input string name, input int max);
        bit ok = 0;
        for (int n = 0; n < max && !ok; n++) begin
            if (mwren) ok = 1;
            else tick();
        end
        chk(name, ok, 1);
    endtask

    task automatic count_writes(input int cycles, output int n, output logic [31:0] d0, output logic [31:0] d1);
        n = 0; d0 = '0; d1 = '0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (mwren) begin
                if (n == 0) d0 = mwdata;
                if (n == 1) d1 = mwdata;
                n++;
            end
        end
    endtask

    int            nw, burst;
    logic [31:0]   w0, w1;
    logic [AW-1:0] va;

    initial begin
        // reset state
        tick(); tick();
        chk("rst_wren", mwren, 0); chk("rst_addr", maddr, 0); chk("rst_wdata", mwdata, 0);
        chk("rst_ack", ack, 0); chk("rst_full", full, 0); chk("rst_err", err, 0);
        rst_n = 1;
        tick();

        // single write held off until blanking
        blank_n = 1;
        push(5, 'h0B);
        tick(); tick(); tick();
        chk("hold_no_wren", mwren, 0);
        blank_n = 0;
        wait_wren("single_wren_seen", 10);
        chk("single_addr", maddr, 5);
        chk("single_data", mwdata, 'h0B);
        tick();
        chk("single_one_write", mwren, 0);
        blank_n = 1;

        // fill to full, refuse fifth, drain in order
        req = 1;
        for (int k = 0; k < 4; k++) begin
            wa = AW'(16 + k); wd = 100 + k;
            tick();
            chk("fill_ack", ack, 1);
        end
        chk("fill_full", full, 1);
        wa = AW'(30); wd = 999;
        tick();
        chk("fifth_no_ack", ack, 0);
        req = 0;
        blank_n = 0;
        wait_wren("drain_seen", 10);
        for (int k = 0; k < 4; k++) begin
            chk("drain_wren", mwren, 1);
            chk("drain_addr", maddr, 16 + k);
            chk("drain_data", mwdata, 100 + k);
            tick();
        end
        chk("drain_end", mwren, 0);
        blank_n = 1;
        tick();

        // blank rises mid-drain
        push(40, 200); push(41, 201); push(42, 202);
        blank_n = 0;
        wait_wren("mid_first_seen", 10);
        chk("mid_first_addr", maddr, 40);
        blank_n = 1;
        tick();
        chk("mid_abort_wren", mwren, 0);
        va = vga_address;
        tick();
        chk("mid_read_addr", maddr, 32'(va));
        blank_n = 0;
        count_writes(12, nw, w0, w1);
        chk("mid_rest_count", nw, 2);
        chk("mid_rest_d0", w0, 201);
        chk("mid_rest_d1", w1, 202);
        blank_n = 1;

        // out-of-range address
        push(70, 'h77);
        chk("oob_err", err, 1);
        chk("oob_full", full, 0);
        blank_n = 0;
        count_writes(8, nw, w0, w1);
        chk("oob_no_write", nw, 0);
        blank_n = 1;

        // duplicate address
        push(9, 'h10); push(9, 'h20);
        blank_n = 0;
        count_writes(12, nw, w0, w1);
`ifdef ARB_COALESCE_EN
        chk("dup_count", nw, 1);
        chk("dup_d0", w0, 'h20);
`else
        chk("dup_count", nw, 2);
        chk("dup_d0", w0, 'h10);
        chk("dup_d1", w1, 'h20);
`endif
        blank_n = 1;

        // reset during drain
        push(50, 1); push(51, 2); push(52, 3);
        blank_n = 0;
        wait_wren("rst_drain_seen", 10);
        #2 rst_n = 0;
        #1;
        chk("rstw_wren", mwren, 0); chk("rstw_addr", maddr, 0); chk("rstw_wdata", mwdata, 0);
        chk("rstw_ack", ack, 0); chk("rstw_full", full, 0); chk("rstw_err", err, 0);
        tick(); tick();
        rst_n = 1;
        count_writes(8, nw, w0, w1);
        chk("rstw_no_write", nw, 0);

        // randomized traffic
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            if (burst == 0) begin
                blank_n = ~blank_n;
                burst = $urandom_range(1, 12);
            end
            burst--;
            req = ($urandom_range(0, 2) == 0);
            wa  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(64, 4095)) : AW'($urandom_range(0, 7));
            wd  = $urandom;
            tick();
        end
        req = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
